// File: rtl/drs_read_scheduler.sv
// DRS4 readout-cycle sequencer: stop domino -> read -> ack -> restart, with trigger gating and counters.
// Optional READ watchdog is compiled in when DRS_READ_TIMEOUT_EN is defined.
module drs_read_scheduler #(
    parameter int STOP_DLY    = 8,
    parameter int RESTART_DLY = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        trig_in,
    input  logic        dfifo_progfull,
    input  logic        drs_read_done,
    output logic [3:0]  drs_state_com,
    output logic        busy,
    output logic [31:0] event_cnt,
    output logic [15:0] lost_cnt,
    input  logic        cnt_clr,
    output logic        timeout_err,
    input  logic        err_clr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STOP    = 3'd1,
        ST_READ    = 3'd2,
        ST_ACK     = 3'd3,
        ST_RESTART = 3'd4
    } state_t;

    localparam logic [3:0]  COM_IDLE     = 4'd0;
    localparam logic [3:0]  COM_STOP     = 4'd4;
    localparam logic [3:0]  COM_READ     = 4'd5;
    localparam logic [3:0]  COM_ACK      = 4'd6;
    localparam logic [3:0]  COM_RESTART  = 4'd1;
    localparam logic [15:0] STOP_LAST    = 16'(STOP_DLY - 1);
    localparam logic [15:0] RESTART_LAST = 16'(RESTART_DLY - 1);

    state_t      state_reg;
    logic [15:0] phase_reg;
    logic        trig_valid;
    logic        accept;
    logic        lost_inc;
    logic        read_timeout;

    assign trig_valid = trig_in & enable;
    assign accept     = trig_valid & (state_reg == ST_IDLE) & ~dfifo_progfull;
    // Anything valid that is not accepted is lost: either busy or no FIFO room.
    assign lost_inc   = trig_valid & ~accept;
    assign state      = state_reg;

`ifdef DRS_READ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

    assign read_timeout = (state_reg == ST_READ) & ~drs_read_done & (phase_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (read_timeout) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    logic        unused_err_clr;
    logic [31:0] unused_timeout_cfg;

    assign read_timeout       = 1'b0;
    assign timeout_err        = 1'b0;
    assign unused_err_clr     = err_clr;
    assign unused_timeout_cfg = TIMEOUT_CYC;
`endif

    // Command and busy are updated together with the state so they never glitch against it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            drs_state_com <= COM_IDLE;
            busy          <= 1'b0;
            phase_reg     <= 16'd0;
        end else begin
            phase_reg <= phase_reg + 16'd1;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_STOP;
                        drs_state_com <= COM_STOP;
                        busy          <= 1'b1;
                        phase_reg     <= 16'd0;
                    end
                end
                ST_STOP: begin
                    if (phase_reg == STOP_LAST) begin
                        state_reg     <= ST_READ;
                        drs_state_com <= COM_READ;
                        phase_reg     <= 16'd0;
                    end
                end
                ST_READ: begin
                    if (drs_read_done || read_timeout) begin
                        state_reg     <= ST_ACK;
                        drs_state_com <= COM_ACK;
                        phase_reg     <= 16'd0;
                    end
                end
                ST_ACK: begin
                    if (!drs_read_done) begin
                        state_reg     <= ST_RESTART;
                        drs_state_com <= COM_RESTART;
                        phase_reg     <= 16'd0;
                    end
                end
                ST_RESTART: begin
                    if (phase_reg == RESTART_LAST) begin
                        state_reg     <= ST_IDLE;
                        drs_state_com <= COM_IDLE;
                        busy          <= 1'b0;
                        phase_reg     <= 16'd0;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    drs_state_com <= COM_IDLE;
                    busy          <= 1'b0;
                    phase_reg     <= 16'd0;
                end
            endcase
        end
    end

    // Clear has priority over a same-cycle increment; lost counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt <= 32'd0;
            lost_cnt  <= 16'd0;
        end else if (cnt_clr) begin
            event_cnt <= 32'd0;
            lost_cnt  <= 16'd0;
        end else begin
            if (accept) begin
                event_cnt <= event_cnt + 32'd1;
            end
            if (lost_inc && (lost_cnt != 16'hFFFF)) begin
                lost_cnt <= lost_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_drs_read_scheduler.sv
// Randomized self-checking bench for drs_read_scheduler; expected command trace is derived
// from segment lengths (stop, read, ack, restart) rather than a cycle-level FSM copy.
module tb_drs_read_scheduler;

    localparam int S  = 8;
    localparam int R  = 16;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        trig_in;
    logic        dfifo_progfull;
    logic        drs_read_done;
    logic [3:0]  drs_state_com;
    logic        busy;
    logic [31:0] event_cnt;
    logic [15:0] lost_cnt;
    logic        cnt_clr;
    logic        timeout_err;
    logic        err_clr;
    logic [2:0]  state;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_event = 0;
    logic [15:0] m_lost = 0;
    logic        m_err = 0;

    drs_read_scheduler #(.STOP_DLY(S), .RESTART_DLY(R), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .trig_in(trig_in),
        .dfifo_progfull(dfifo_progfull), .drs_read_done(drs_read_done),
        .drs_state_com(drs_state_com), .busy(busy), .event_cnt(event_cnt),
        .lost_cnt(lost_cnt), .cnt_clr(cnt_clr), .timeout_err(timeout_err),
        .err_clr(err_clr), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Command visible k cycles after the accepting edge; READ ends after interval u, ACK after v.
    function automatic logic [3:0] exp_com_at(input int k, input int u, input int v);
        if (k < 1)      return 4'd0;
        if (k <= S)     return 4'd4;
        if (k <= u)     return 4'd5;
        if (k <= v)     return 4'd6;
        if (k <= v + R) return 4'd1;
        return 4'd0;
    endfunction

    function automatic logic [2:0] state_of(input logic [3:0] com);
        case (com)
            4'd4:    return 3'd1;
            4'd5:    return 3'd2;
            4'd6:    return 3'd3;
            4'd1:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // One full readout sequence. trig_mode: 0 none, 1 every 5 cycles, 2 random (with random enable).
    task automatic run_seq(input int u_off, input int v_len, input int trig_mode,
                           input bit clr_first, input bit no_done, input string name);
        int u;
        int v;
        int total;
        logic [3:0] ec;
        logic t;
        logic e;
        u = S + 1 + u_off;
        v = u + v_len;
        total = v + R + 2;
        trig_in = 1'b1;
        enable = 1'b1;
        drs_read_done = 1'b0;
        cnt_clr = clr_first;
        if (clr_first) begin
            m_event = 0;
            m_lost = 0;
        end else begin
            m_event = m_event + 1;
        end
        for (int k = 1; k <= total; k++) begin
            tick();
            cnt_clr = 1'b0;
            if (no_done && k == u + 1) m_err = 1'b1;
            if (k == 1) begin
                n_cmp++;
                if (event_cnt !== m_event) begin
                    n_err++;
                    $display("FAIL %s event_at_accept: got %0d expected %0d", name, event_cnt, m_event);
                end
            end
            ec = exp_com_at(k, u, v);
            n_cmp++;
            if (drs_state_com !== ec || busy !== (ec != 4'd0) || state !== state_of(ec)) begin
                n_err++;
                $display("FAIL %s cycle%0d com/busy/state: got %0d/%0b/%0d expected %0d/%0b/%0d",
                         name, k, drs_state_com, busy, state, ec, (ec != 4'd0), state_of(ec));
            end
            n_cmp++;
            if (timeout_err !== m_err) begin
                n_err++;
                $display("FAIL %s cycle%0d timeout_err: got %0b expected %0b", name, k, timeout_err, m_err);
            end
            drs_read_done = !no_done && (k >= u) && (k < v);
            if (k <= v + R) begin
                case (trig_mode)
                    1:       t = (k % 5 == 0);
                    2:       t = ($urandom_range(0, 3) == 0);
                    default: t = 1'b0;
                endcase
                e = (trig_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                t = 1'b0;
                e = 1'b1;
            end
            trig_in = t;
            enable = e;
            if (t && e && m_lost != 16'hFFFF) m_lost = m_lost + 1;
        end
        trig_in = 1'b0;
        enable = 1'b1;
        n_cmp++;
        if (event_cnt !== m_event || lost_cnt !== m_lost) begin
            n_err++;
            $display("FAIL %s counters: got event=%0d lost=%0d expected event=%0d lost=%0d",
                     name, event_cnt, lost_cnt, m_event, m_lost);
        end
        $display("seq %s: u=%0d v=%0d event=%0d lost=%0d", name, u, v, event_cnt, lost_cnt);
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if (drs_state_com !== 4'd0 || busy !== 1'b0 || state !== 3'd0 || event_cnt !== 32'd0 ||
            lost_cnt !== 16'd0 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got com=%0d busy=%0b state=%0d ev=%0d lost=%0d err=%0b expected all 0",
                     drs_state_com, busy, state, event_cnt, lost_cnt, timeout_err);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (drs_state_com !== 4'd0 || busy !== 1'b0 || state !== 3'd0) begin
            n_err++;
            $display("FAIL reset_release_idle: got com=%0d busy=%0b state=%0d expected 0/0/0",
                     drs_state_com, busy, state);
        end
        $display("reset: done");
    endtask

    task automatic test_single();
        run_seq(19, 2, 0, 1'b0, 1'b0, "single");
    endtask

    task automatic test_progfull();
        dfifo_progfull = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trig_in = 1'b1;
            tick();
            trig_in = 1'b0;
            m_lost = m_lost + 1;
            n_cmp++;
            if (drs_state_com !== 4'd0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL progfull_idle%0d: got com=%0d busy=%0b expected 0/0", i, drs_state_com, busy);
            end
            tick();
        end
        dfifo_progfull = 1'b0;
        n_cmp++;
        if (event_cnt !== m_event || lost_cnt !== m_lost) begin
            n_err++;
            $display("FAIL progfull_counters: got event=%0d lost=%0d expected event=%0d lost=%0d",
                     event_cnt, lost_cnt, m_event, m_lost);
        end
        $display("progfull: event=%0d lost=%0d", event_cnt, lost_cnt);
    endtask

    task automatic test_back_to_back();
        run_seq(6, 3, 1, 1'b0, 1'b0, "every5");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_seq($urandom_range(0, 15), $urandom_range(1, 6), 2, 1'b0, 1'b0, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_cnt_clr();
        run_seq($urandom_range(0, 5), 1, 2, 1'b1, 1'b0, "clr_accept");
        dfifo_progfull = 1'b1;
        enable = 1'b1;
        trig_in = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            tick();
            if (m_lost != 16'hFFFF) m_lost = m_lost + 1;
        end
        n_cmp++;
        if (lost_cnt !== 16'hFFFF || lost_cnt !== m_lost || event_cnt !== m_event) begin
            n_err++;
            $display("FAIL lost_saturate: got lost=%0h event=%0d expected lost=%0h event=%0d",
                     lost_cnt, event_cnt, m_lost, m_event);
        end
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        trig_in = 1'b0;
        dfifo_progfull = 1'b0;
        m_lost = 0;
        m_event = 0;
        n_cmp++;
        if (lost_cnt !== 16'd0 || event_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL clr_over_inc: got lost=%0h event=%0d expected 0/0", lost_cnt, event_cnt);
        end
        $display("cnt_clr: lost=%0h event=%0d", lost_cnt, event_cnt);
    endtask

    task automatic test_timeout();
`ifdef DRS_READ_TIMEOUT_EN
        run_seq(TO - 1, 1, 0, 1'b0, 1'b1, "timeout");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr: got %0b expected 0", timeout_err);
        end
`else
        int w;
        trig_in = 1'b1;
        enable = 1'b1;
        m_event = m_event + 1;
        tick();
        trig_in = 1'b0;
        repeat (S + 200) tick();
        n_cmp++;
        if (drs_state_com !== 4'd5 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL read_no_watchdog: got com=%0d err=%0b expected 5/0", drs_state_com, timeout_err);
        end
        drs_read_done = 1'b1;
        tick();
        drs_read_done = 1'b0;
        w = 0;
        while (busy !== 1'b0 && w < 100) begin
            tick();
            w++;
        end
        n_cmp++;
        if (busy !== 1'b0 || event_cnt !== m_event) begin
            n_err++;
            $display("FAIL idle_after_read: got busy=%0b event=%0d expected 0/%0d", busy, event_cnt, m_event);
        end
`endif
        $display("timeout: err=%0b com=%0d", timeout_err, drs_state_com);
    endtask

    task automatic test_async_reset();
        trig_in = 1'b1;
        enable = 1'b1;
        tick();
        trig_in = 1'b0;
        repeat (S + 4) tick();
        n_cmp++;
        if (drs_state_com !== 4'd5) begin
            n_err++;
            $display("FAIL pre_reset_read: got com=%0d expected 5", drs_state_com);
        end
        #2;
        rst_n = 1'b0;
        #1;
        m_event = 0;
        m_lost = 0;
        m_err = 1'b0;
        n_cmp++;
        if (drs_state_com !== 4'd0 || busy !== 1'b0 || state !== 3'd0 || event_cnt !== 32'd0 || lost_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL async_reset: got com=%0d busy=%0b state=%0d ev=%0d lost=%0d expected all 0",
                     drs_state_com, busy, state, event_cnt, lost_cnt);
        end
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
        tick();
        run_seq($urandom_range(0, 10), $urandom_range(1, 4), 2, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        trig_in = 1'b0;
        dfifo_progfull = 1'b0;
        drs_read_done = 1'b0;
        cnt_clr = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_single();
        test_progfull();
        test_back_to_back();
        test_random();
        test_cnt_clr();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
